bcd_field_editor: RTL and testbench

BCD_FIELD_EDITOR -- requirements
Module: bcd_field_editor

---
 rtl/bcd_edit_pkg.sv | 55 +++++
 rtl/bcd_field_editor_if.sv | 26 ++
 rtl/btn_repeat.sv | 80 ++++++++
 rtl/bcd_field_editor.sv | 93 +++++++++
 tb/tb_bcd_field_editor.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bcd_edit_pkg.sv
// Shared constants, state types and BCD helpers for the field editor.
// Field index map, per-field MIN/MAX table, BCD step and range check.
package bcd_edit_pkg;

   localparam int F_SEC   = 0;
   localparam int F_MIN   = 1;
   localparam int F_HOUR  = 2;
   localparam int F_DAY   = 3;
   localparam int F_MONTH = 4;
   localparam int F_YEAR  = 5;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_HOLD,
      RPT_REP
   } rpt_state_t;

   function automatic logic [7:0] field_min(input int idx);
      case (idx)
         F_DAY, F_MONTH: return 8'h01;
         default:        return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] field_max(input int idx);
      case (idx)
         F_SEC, F_MIN: return 8'h59;
         F_HOUR:       return 8'h23;
         F_DAY:        return 8'h31;
         F_MONTH:      return 8'h12;
         default:      return 8'h99;
      endcase
   endfunction

   // Valid BCD digits order the same as their binary encoding,
   // so range limits compare directly on the packed byte.
   function automatic logic in_range(input logic [7:0] v,
                                     input int idx);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
             (v >= field_min(idx)) && (v <= field_max(idx));
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/bcd_field_editor_if.sv
// Editor control/data bundle: buttons, select, load and field outputs.
// master drives buttons/sel/load; slave (editor) returns fields/changed.
interface bcd_field_editor_if #(
   parameter int NUM_FIELDS = 6
);
   localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

   logic                    Up;
   logic                    Down;
   logic                    edit_en;
   logic [SEL_W-1:0]        sel;
   logic                    load;
   logic [8*NUM_FIELDS-1:0] load_data;
   logic [8*NUM_FIELDS-1:0] fields;
   logic                    changed;

   modport master (
      output Up, Down, edit_en, sel, load, load_data,
      input  fields, changed
   );

   modport slave (
      input  Up, Down, edit_en, sel, load, load_data,
      output fields, changed
   );
endinterface

// File: rtl/btn_repeat.sv
// One button: rising-edge step plus hold-delay / auto-repeat steps.
// Ports: clk, reset, btn (level), enable (gate), step (comb pulse).
module btn_repeat
   import bcd_edit_pkg::*;
#(
   parameter int HOLD_DLY   = 50_000_000,
   parameter int REP_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic enable,
   output logic step
);
   localparam int MAXC = (HOLD_DLY > REP_PERIOD) ? HOLD_DLY : REP_PERIOD;
   localparam int CW   = $clog2(MAXC + 1);

   rpt_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prev_q;
   logic          rise;

   assign rise = btn & ~prev_q;

   // prev_q resets high so a button held across reset is not
   // mistaken for a fresh press.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RPT_IDLE;
         cnt_q   <= '0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= btn;
      end
   end

   // cnt_q equals the number of clocks since the last step.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step    = 1'b0;
      if (!btn || !enable) begin
         state_d = RPT_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RPT_IDLE: begin
               if (rise) begin
                  step    = 1'b1;
                  state_d = RPT_HOLD;
                  cnt_d   = CW'(1);
               end
            end
            RPT_HOLD: begin
               if (cnt_q == CW'(HOLD_DLY)) begin
                  step    = 1'b1;
                  state_d = RPT_REP;
                  cnt_d   = CW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RPT_REP: begin
               if (cnt_q == CW'(REP_PERIOD)) begin
                  step  = 1'b1;
                  cnt_d = CW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = RPT_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end
endmodule

// File: rtl/bcd_field_editor.sv
// Multi-field two-digit BCD editor driven by Up/Down buttons.
// Ports: clk, reset (sync, active high), bus (slave: buttons, sel,
// load/load_data in; fields, changed out).
module bcd_field_editor
   import bcd_edit_pkg::*;
#(
   parameter int NUM_FIELDS = 6,
   parameter int HOLD_DLY   = 50_000_000,
   parameter int REP_PERIOD = 10_000_000
) (
   input  logic                clk,
   input  logic                reset,
   bcd_field_editor_if.slave   bus
);
   localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

   logic [7:0]       fields_q [NUM_FIELDS];
   logic             changed_q;
   logic             sel_ok;
   logic             gate;
   logic [SEL_W-1:0] sel_idx;
   logic             up_step, dn_step;
   logic             up_only, dn_only;
   logic [7:0]       cur, cur_min, cur_max, nxt;

   assign sel_ok  = int'(bus.sel) < NUM_FIELDS;
   assign gate    = bus.edit_en & sel_ok;
   assign sel_idx = sel_ok ? bus.sel : '0;

   btn_repeat #(
      .HOLD_DLY   (HOLD_DLY),
      .REP_PERIOD (REP_PERIOD)
   ) u_up (
      .clk    (clk),
      .reset  (reset),
      .btn    (bus.Up),
      .enable (gate),
      .step   (up_step)
   );

   btn_repeat #(
      .HOLD_DLY   (HOLD_DLY),
      .REP_PERIOD (REP_PERIOD)
   ) u_dn (
      .clk    (clk),
      .reset  (reset),
      .btn    (bus.Down),
      .enable (gate),
      .step   (dn_step)
   );

   // Coincident up and down steps cancel.
   assign up_only = up_step & ~dn_step;
   assign dn_only = dn_step & ~up_step;

   // Single shared step datapath for the selected field.
   always_comb begin
      cur     = fields_q[sel_idx];
      cur_min = field_min(int'(sel_idx));
      cur_max = field_max(int'(sel_idx));
      nxt     = cur;
      if (up_only)
         nxt = (cur == cur_max) ? cur_min : bcd_inc(cur);
      else if (dn_only)
         nxt = (cur == cur_min) ? cur_max : bcd_dec(cur);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            fields_q[i] <= field_min(i);
         changed_q <= 1'b0;
      end else if (bus.load) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            fields_q[i] <= in_range(bus.load_data[8*i +: 8], i) ?
                           bus.load_data[8*i +: 8] : field_min(i);
         changed_q <= 1'b0;
      end else if (up_only || dn_only) begin
         fields_q[sel_idx] <= nxt;
         changed_q         <= 1'b1;
      end else begin
         changed_q <= 1'b0;
      end
   end

   always_comb begin
      bus.fields = '0;
      for (int i = 0; i < NUM_FIELDS; i++)
         bus.fields[8*i +: 8] = fields_q[i];
   end

   assign bus.changed = changed_q;
endmodule

// File: tb/tb_bcd_field_editor.sv
// Directed self-checking bench for bcd_field_editor.
// Short HOLD_DLY/REP_PERIOD so auto-repeat timing is observable.
module tb_bcd_field_editor;
   import bcd_edit_pkg::*;

   localparam int NF = 6;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bcd_field_editor_if #(.NUM_FIELDS(NF)) bus ();

   bcd_field_editor #(
      .NUM_FIELDS (NF),
      .HOLD_DLY   (8),
      .REP_PERIOD (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [47:0] d);
      bus.load_data = d;
      bus.load      = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic pulse_up();
      bus.Up = 1'b1;
      tick();
      bus.Up = 1'b0;
   endtask

   task automatic pulse_dn();
      bus.Down = 1'b1;
      tick();
      bus.Down = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.Up        = 1'b0;
      bus.Down      = 1'b0;
      bus.edit_en   = 1'b1;
      bus.sel       = '0;
      bus.load      = 1'b0;
      bus.load_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      chk("reset_fields", 64'(bus.fields), 64'h00_01_01_00_00_00);
      chk("reset_changed", 64'(bus.changed), 64'h0);

      do_load(48'h00_01_01_23_00_00);
      chk("load_hours", 64'(bus.fields), 64'h00_01_01_23_00_00);
      chk("load_changed", 64'(bus.changed), 64'h0);

      bus.sel = 3'(F_HOUR);
      pulse_up();
      chk("hour_wrap", 64'(bus.fields), 64'h00_01_01_00_00_00);
      chk("hour_changed", 64'(bus.changed), 64'h1);
      tick();
      chk("changed_pulse", 64'(bus.changed), 64'h0);

      bus.sel = 3'(F_MONTH);
      pulse_dn();
      chk("month_wrap", 64'(bus.fields), 64'h00_12_01_00_00_00);
      tick();
      do_load(48'h99_1A_32_00_00_00);
      chk("load_invalid", 64'(bus.fields), 64'h99_01_01_00_00_00);

      do_load(48'h99_01_01_00_10_00);
      bus.sel = 3'(F_MIN);
      pulse_dn();
      chk("min_borrow", 64'(bus.fields), 64'h99_01_01_00_09_00);
      tick();

      bus.sel = 3'(F_SEC);
      pulse_dn();
      chk("sec_dn_wrap", 64'(bus.fields), 64'h99_01_01_00_09_59);
      tick();
      pulse_up();
      chk("sec_up_wrap", 64'(bus.fields), 64'h99_01_01_00_09_00);
      tick();

      bus.Up = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("hold_chg_%0d", k), 64'(bus.changed),
             64'((k == 0) || (k == 8) || (k == 12) || (k == 16)));
      end
      bus.Up = 1'b0;
      chk("hold_sec", 64'(bus.fields), 64'h99_01_01_00_09_04);
      tick();

      bus.Up   = 1'b1;
      bus.Down = 1'b1;
      tick();
      chk("both_fields", 64'(bus.fields), 64'h99_01_01_00_09_04);
      chk("both_changed", 64'(bus.changed), 64'h0);
      bus.Up   = 1'b0;
      bus.Down = 1'b0;
      tick();

      bus.edit_en = 1'b0;
      pulse_up();
      chk("dis_fields", 64'(bus.fields), 64'h99_01_01_00_09_04);
      chk("dis_changed", 64'(bus.changed), 64'h0);
      tick();
      bus.edit_en = 1'b1;

      bus.sel = 3'd6;
      pulse_up();
      chk("badsel_fields", 64'(bus.fields), 64'h99_01_01_00_09_04);
      chk("badsel_changed", 64'(bus.changed), 64'h0);
      tick();
      bus.sel = 3'(F_SEC);

      bus.Up = 1'b1;
      reset  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("rst_hold_fields", 64'(bus.fields), 64'h00_01_01_00_00_00);
      chk("rst_hold_chg", 64'(bus.changed), 64'h0);
      repeat (10) tick();
      chk("rst_hold_long", 64'(bus.fields), 64'h00_01_01_00_00_00);
      bus.Up = 1'b0;
      tick();
      pulse_up();
      chk("repress_fields", 64'(bus.fields), 64'h00_01_01_00_00_01);
      chk("repress_chg", 64'(bus.changed), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
